// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO write sequencer for the E stage: MTHI/MTLO pass-through, multi-cycle multiply
// and a 32-step restoring divide, with E-stage stall while an operation is in flight.
module hilo_muldiv_ctrl #(
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [63:0] hilo_cur,
  input  logic        flush,
  output logic        stall_e,
  output logic        hilo_we,
  output logic [63:0] hilo_wdata
);

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [31:0] opa_q;      // multiplicand, or dividend/quotient shift register
  logic [31:0] opb_q;      // multiplier, or divisor magnitude
  logic [31:0] rem_q;
  logic        mul_signed_q;
  logic        neg_quo_q;
  logic        neg_rem_q;

  logic        is_mul, is_div, div_ok;
  logic [63:0] mul_a, mul_b, product;
  logic [32:0] rem_sh, diff;
  logic        fits;
  logic [31:0] rem_nxt, quo_nxt, rem_fix, quo_fix;
  logic [31:0] abs_a, abs_b;
  logic        sa, sb;

  always_comb begin
    is_mul  = (op == OpMult) || (op == OpMultu);
    is_div  = (op == OpDiv) || (op == OpDivu);
    div_ok  = src_b != 32'd0;
    stall_e = rst & ~flush & ((state_q != StIdle) |
              ((state_q == StIdle) & start & is_mul) |
              ((state_q == StIdle) & start & is_div & div_ok));

    mul_a   = {{32{mul_signed_q & opa_q[31]}}, opa_q};
    mul_b   = {{32{mul_signed_q & opb_q[31]}}, opb_q};
    product = mul_a * mul_b;

    // One restoring step; the final step feeds the write data directly.
    rem_sh  = {rem_q, opa_q[31]};
    diff    = rem_sh - {1'b0, opb_q};
    fits    = ~diff[32];
    rem_nxt = fits ? diff[31:0] : rem_sh[31:0];
    quo_nxt = {opa_q[30:0], fits};
    quo_fix = neg_quo_q ? (32'd0 - quo_nxt) : quo_nxt;
    rem_fix = neg_rem_q ? (32'd0 - rem_nxt) : rem_nxt;

    sa      = (op == OpDiv) & src_a[31];
    sb      = (op == OpDiv) & src_b[31];
    abs_a   = sa ? (32'd0 - src_a) : src_a;
    abs_b   = sb ? (32'd0 - src_b) : src_b;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      cnt_q        <= 5'd0;
      opa_q        <= 32'd0;
      opb_q        <= 32'd0;
      rem_q        <= 32'd0;
      mul_signed_q <= 1'b0;
      neg_quo_q    <= 1'b0;
      neg_rem_q    <= 1'b0;
      hilo_we      <= 1'b0;
      hilo_wdata   <= 64'd0;
    end else begin
      hilo_we <= 1'b0;
      if (flush) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              case (op)
                OpMthi: begin
                  hilo_we    <= 1'b1;
                  hilo_wdata <= {src_a, hilo_cur[31:0]};
                end
                OpMtlo: begin
                  hilo_we    <= 1'b1;
                  hilo_wdata <= {hilo_cur[63:32], src_a};
                end
                OpMult, OpMultu: begin
                  state_q      <= StMul;
                  cnt_q        <= 5'(MUL_CYCLES - 1);
                  opa_q        <= src_a;
                  opb_q        <= src_b;
                  mul_signed_q <= (op == OpMult);
                end
                OpDiv, OpDivu: begin
                  if (div_ok) begin
                    state_q   <= StDiv;
                    cnt_q     <= 5'd31;
                    opa_q     <= abs_a;
                    opb_q     <= abs_b;
                    rem_q     <= 32'd0;
                    neg_quo_q <= sa ^ sb;
                    neg_rem_q <= sa;
                  end
                end
                default: ;
              endcase
            end
          end
          StMul: begin
            if (cnt_q == 5'd0) begin
              state_q    <= StIdle;
              hilo_we    <= 1'b1;
              hilo_wdata <= product;
            end else begin
              cnt_q <= cnt_q - 5'd1;
            end
          end
          StDiv: begin
            rem_q <= rem_nxt;
            opa_q <= quo_nxt;
            if (cnt_q == 5'd0) begin
              state_q    <= StIdle;
              hilo_we    <= 1'b1;
              hilo_wdata <= {rem_fix, quo_fix};
            end else begin
              cnt_q <= cnt_q - 5'd1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Scoreboard bench for hilo_muldiv_ctrl: stimulus pushes expected HI/LO writes,
// a negedge monitor pops and compares every hilo_we pulse.
module tb_hilo_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic [63:0] hilo_cur;
  logic        flush;
  logic        stall_e;
  logic        hilo_we;
  logic [63:0] hilo_wdata;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] sb_q[$];

  hilo_muldiv_ctrl #(.MUL_CYCLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .src_a      (src_a),
    .src_b      (src_b),
    .hilo_cur   (hilo_cur),
    .flush      (flush),
    .stall_e    (stall_e),
    .hilo_we    (hilo_we),
    .hilo_wdata (hilo_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (hilo_we === 1'b1) begin
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got %h expected no write", hilo_wdata);
      end else begin
        chk("hilo_wdata", hilo_wdata, sb_q.pop_front());
      end
    end
  end

  // Issue an op now, count stall cycles, leave start low one cycle past the release.
  task automatic issue(input string name, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input int exp_stall, input bit exp_w,
                       input logic [63:0] exp_d);
    int n = 0;
    start = 1'b1; op = o; src_a = a; src_b = b;
    if (exp_w) sb_q.push_back(exp_d);
    #1;
    while (stall_e && n < 100) begin
      n++;
      @(posedge clk); #1;
      start = 1'b0; op = 3'd0;
      #1;
    end
    if (n == 0) begin
      @(posedge clk); #1;
    end
    start = 1'b0; op = 3'd0;
    chk({name, "_stall"}, 64'(n), 64'(exp_stall));
  endtask

  task automatic drain(input string name);
    repeat (3) @(posedge clk);
    #1;
    chk({name, "_drained"}, 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b1; op = 3'd1; src_a = 32'd5; src_b = 32'd3;
    hilo_cur = 64'hAAAABBBB_CCCCDDDD; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 64'(stall_e), 64'd0);
    chk("rst_we", 64'(hilo_we), 64'd0);
    chk("rst_wdata", hilo_wdata, 64'd0);
    start = 1'b0; op = 3'd0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Multiply
    issue("mult", 3'd1, 32'hFFFFFFFE, 32'd3, 3, 1'b1, 64'hFFFFFFFF_FFFFFFFA);
    issue("multu", 3'd2, 32'hFFFFFFFE, 32'd3, 3, 1'b1, 64'h00000002_FFFFFFFA);
    drain("mul");

    // Divide
    issue("div_m7_2", 3'd3, 32'hFFFFFFF9, 32'd2, 33, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD});
    issue("divu_7_2", 3'd4, 32'd7, 32'd2, 33, 1'b1, {32'd1, 32'd3});
    issue("divu_max_1", 3'd4, 32'hFFFFFFFF, 32'd1, 33, 1'b1, {32'd0, 32'hFFFFFFFF});
    issue("div_7_m2", 3'd3, 32'd7, 32'hFFFFFFFE, 33, 1'b1, {32'd1, 32'hFFFFFFFD});
    issue("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 33, 1'b1, {32'd0, 32'h80000000});
    drain("div");

    // Divide by zero: never accepted, no write over 40 cycles
    issue("div_by0", 3'd3, 32'd5, 32'd0, 0, 1'b0, 64'd0);
    repeat (40) @(posedge clk);
    #1;

    // MTHI / MTLO back to back
    issue("mthi", 3'd5, 32'h12345678, 32'd0, 0, 1'b1, 64'h12345678_CCCCDDDD);
    issue("mtlo", 3'd6, 32'h12345678, 32'd0, 0, 1'b1, 64'hAAAABBBB_12345678);
    drain("mt");

    // Flush in divide cycle 10, then DIVU 9/4
    start = 1'b1; op = 3'd3; src_a = 32'd100; src_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    #1;
    chk("flush_stall", 64'(stall_e), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    chk("post_flush_stall", 64'(stall_e), 64'd0);
    issue("divu_9_4", 3'd4, 32'd9, 32'd4, 33, 1'b1, {32'd1, 32'd2});
    drain("flush");

    // Reset during multiply, start held while in reset
    start = 1'b1; op = 3'd1; src_a = 32'd6; src_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    rst = 1'b0; start = 1'b1; op = 3'd1;
    #1;
    chk("rst_mid_stall", 64'(stall_e), 64'd0);
    @(posedge clk); #1;
    chk("rst_mid_we", 64'(hilo_we), 64'd0);
    chk("rst_mid_wdata", hilo_wdata, 64'd0);
    @(posedge clk); #1;
    chk("rst_hold_stall", 64'(stall_e), 64'd0);
    start = 1'b0; op = 3'd0; rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    // Back-to-back MULT then DIV accepted on the release cycle
    issue("b2b_mult", 3'd1, 32'h00010000, 32'h00010000, 3, 1'b1, {32'd1, 32'd0});
    issue("b2b_div", 3'd3, 32'd100, 32'd7, 33, 1'b1, {32'd2, 32'd14});
    drain("b2b");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
